// File: rtl/mem_copy_pkg.sv
// Shared definitions for the memory copy/fill engine and its memory model.
package mem_copy_pkg;

    localparam int MEM_ADDR_W = 8;
    localparam int MEM_DATA_W = 32;
    localparam int MEM_WORDS  = 256;

    localparam logic OP_COPY = 1'b0;
    localparam logic OP_FILL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WRITE = 3'd2,
        ST_FILL  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/mem_copy_engine.sv
// Data-port initiator that copies or fills blocks of words in the unified memory.
// Outputs decode from registered state only, so there is no input-to-output path.
module mem_copy_engine
    import mem_copy_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              op,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W:0]   count,
    input  logic [DATA_W-1:0] fill_value,
    output logic              busy,
    output logic              done,
    output logic              data_mem_write,
    output logic [ADDR_W-1:0] data_address,
    output logic [DATA_W-1:0] data_write_data,
    input  logic [DATA_W-1:0] data_read_data
);

    state_t            state_reg;
    logic [ADDR_W:0]   idx_reg;
    logic [ADDR_W:0]   count_reg;
    logic [ADDR_W-1:0] src_reg;
    logic [ADDR_W-1:0] dst_reg;
    logic [DATA_W-1:0] fill_reg;
    logic [DATA_W-1:0] hold_reg;

    logic [ADDR_W:0]   idx_inc;
    logic              last;
    logic [ADDR_W-1:0] src_sum;
    logic [ADDR_W-1:0] dst_sum;

    // Index is one bit wider than the address so a 256-word transfer terminates.
    assign idx_inc = idx_reg + {{ADDR_W{1'b0}}, 1'b1};
    assign last    = (idx_inc == count_reg);
    assign src_sum = src_reg + idx_reg[ADDR_W-1:0];
    assign dst_sum = dst_reg + idx_reg[ADDR_W-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            idx_reg   <= '0;
            count_reg <= '0;
            src_reg   <= '0;
            dst_reg   <= '0;
            fill_reg  <= '0;
            hold_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        src_reg   <= src_addr;
                        dst_reg   <= dst_addr;
                        count_reg <= count;
                        fill_reg  <= fill_value;
                        idx_reg   <= '0;
                        if (count == '0)
                            state_reg <= ST_DONE;
                        else if (op == OP_FILL)
                            state_reg <= ST_FILL;
                        else
                            state_reg <= ST_READ;
                    end
                end
                ST_READ: begin
                    hold_reg  <= data_read_data;
                    state_reg <= ST_WRITE;
                end
                ST_WRITE: begin
                    idx_reg   <= idx_inc;
                    state_reg <= last ? ST_DONE : ST_READ;
                end
                ST_FILL: begin
                    idx_reg <= idx_inc;
                    if (last)
                        state_reg <= ST_DONE;
                end
                ST_DONE: state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy            = 1'b0;
        done            = 1'b0;
        data_mem_write  = 1'b0;
        data_address    = '0;
        data_write_data = '0;
        case (state_reg)
            ST_READ: begin
                busy         = 1'b1;
                data_address = src_sum;
            end
            ST_WRITE: begin
                busy            = 1'b1;
                data_mem_write  = 1'b1;
                data_address    = dst_sum;
                data_write_data = hold_reg;
            end
            ST_FILL: begin
                busy            = 1'b1;
                data_mem_write  = 1'b1;
                data_address    = dst_sum;
                data_write_data = fill_reg;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Scoreboard bench for mem_copy_engine: a word-level reference memory predicts
// every write and the completion cycle; a monitor process checks the DUT port.
module tb_mem_copy_engine;
    import mem_copy_pkg::*;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic        op;
    logic [7:0]  src_addr;
    logic [7:0]  dst_addr;
    logic [8:0]  count;
    logic [31:0] fill_value;
    logic        busy;
    logic        done;
    logic        data_mem_write;
    logic [7:0]  data_address;
    logic [31:0] data_write_data;
    logic [31:0] data_read_data;

    logic [31:0] mem     [MEM_WORDS];
    logic [31:0] ref_mem [MEM_WORDS];

    wr_t exp_wr[$];
    int  exp_done[$];
    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    int  done_seen = 0;
    int  busy_cycles = 0;

    mem_copy_engine dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .op              (op),
        .src_addr        (src_addr),
        .dst_addr        (dst_addr),
        .count           (count),
        .fill_value      (fill_value),
        .busy            (busy),
        .done            (done),
        .data_mem_write  (data_mem_write),
        .data_address    (data_address),
        .data_write_data (data_write_data),
        .data_read_data  (data_read_data)
    );

    assign data_read_data = mem[data_address];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic mem_proc();
        forever begin
            @(posedge clk);
            if (data_mem_write)
                mem[data_address] <= data_write_data;
        end
    endtask

    task automatic monitor();
        wr_t e;
        int  ec;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (busy) busy_cycles++;
                if (data_mem_write) begin
                    if (exp_wr.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_write actual=addr %0h data %0h required=no write",
                                 data_address, data_write_data);
                    end else begin
                        e = exp_wr.pop_front();
                        chk("write_addr", {56'd0, data_address}, {56'd0, e.addr});
                        chk("write_data", {32'd0, data_write_data}, {32'd0, e.data});
                        $display("write addr=%02h data=%08h", data_address, data_write_data);
                    end
                end
                if (done) begin
                    done_seen++;
                    if (exp_done.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_done actual=done at cycle %0d required=no done", cyc);
                    end else begin
                        ec = exp_done.pop_front();
                        chk("done_cycle", 64'(cyc), 64'(ec));
                        $display("done cycle=%0d", cyc);
                    end
                end
            end
        end
    endtask

    // Reference: ascending word order over the current memory image, addresses mod 256.
    task automatic model(input logic o, input int src, input int dst, input int cnt, input logic [31:0] fv);
        wr_t w;
        for (int i = 0; i < cnt; i++) begin
            w.addr = 8'((dst + i) % MEM_WORDS);
            w.data = (o == OP_FILL) ? fv : ref_mem[(src + i) % MEM_WORDS];
            ref_mem[w.addr] = w.data;
            exp_wr.push_back(w);
        end
    endtask

    task automatic mem_compare(input string name);
        int bad = 0;
        for (int i = 0; i < MEM_WORDS; i++)
            if (mem[i] !== ref_mem[i]) bad++;
        chk(name, 64'(bad), 64'd0);
    endtask

    task automatic run(input logic o, input int src, input int dst, input int cnt,
                       input logic [31:0] fv, input bit poke_start);
        int s, lat, b0, d0;
        model(o, src, dst, cnt, fv);
        lat = (cnt == 0) ? 1 : ((o == OP_FILL) ? cnt + 1 : 2 * cnt + 1);
        b0 = busy_cycles;
        d0 = done_seen;
        @(posedge clk); #1;
        start = 1'b1; op = o; src_addr = 8'(src); dst_addr = 8'(dst);
        count = 9'(cnt); fill_value = fv;
        @(posedge clk); #1;
        s = cyc;
        exp_done.push_back(s + lat - 1);
        start = 1'b0;
        op = 1'($urandom); src_addr = 8'($urandom); dst_addr = 8'($urandom);
        count = 9'($urandom_range(1, 255)); fill_value = $urandom;
        $display("start op=%0d src=%02h dst=%02h count=%0d fill=%08h", o, src, dst, cnt, fv);
        if (poke_start) begin
            repeat (2) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        for (int k = 0; k < 2 * cnt + 20 && done_seen == d0; k++)
            @(posedge clk);
        chk("done_count", 64'(done_seen), 64'(d0 + 1));
        @(negedge clk);
        chk("writes_left", 64'(exp_wr.size()), 64'd0);
        chk("busy_cycles", 64'(busy_cycles - b0),
            64'((cnt == 0) ? 0 : ((o == OP_FILL) ? cnt : 2 * cnt)));
        mem_compare("mem_contents");
        exp_wr.delete();
        exp_done.delete();
    endtask

    initial begin
        int d0;
        rst = 1'b0;
        start = 1'b0; op = 1'b0; src_addr = '0; dst_addr = '0; count = '0; fill_value = '0;
        for (int i = 0; i < MEM_WORDS; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        fork
            mem_proc();
            monitor();
        join_none

        #3;
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_strobe", {63'd0, data_mem_write}, 64'd0);
        chk("reset_addr", {56'd0, data_address}, 64'd0);
        chk("reset_wdata", {32'd0, data_write_data}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        run(OP_COPY, 'h10, 'h80, 4, 32'h0, 1'b0);
        run(OP_FILL, 0, 'h20, 3, 32'hDEADBEEF, 1'b0);
        run(OP_COPY, 'hFE, 'h40, 4, 32'h0, 1'b0);
        run(OP_FILL, 0, 'h37, 256, 32'h5A5A_0F0F, 1'b0);
        run(OP_COPY, 'h33, 'h90, 0, 32'h0, 1'b0);

        @(negedge clk);
        mem['h10] = 32'd1; mem['h11] = 32'd2; mem['h12] = 32'd3;
        ref_mem['h10] = 32'd1; ref_mem['h11] = 32'd2; ref_mem['h12] = 32'd3;
        run(OP_COPY, 'h10, 'h11, 3, 32'h0, 1'b0);
        chk("overlap_11", {32'd0, mem['h11]}, 64'd1);
        chk("overlap_12", {32'd0, mem['h12]}, 64'd1);
        chk("overlap_13", {32'd0, mem['h13]}, 64'd1);

        run(OP_COPY, 'h05, 'hA0, 6, 32'h0, 1'b1);
        run(OP_FILL, 0, 'hF0, 8, 32'hCAFE_F00D, 1'b1);

        // Reset during the second write of a 4-word copy: only word 0 lands.
        model(OP_COPY, 'h60, 'hC0, 1, 32'h0);
        d0 = done_seen;
        @(posedge clk); #1;
        start = 1'b1; op = OP_COPY; src_addr = 8'h60; dst_addr = 8'hC0; count = 9'd4;
        @(posedge clk); #1;
        start = 1'b0;
        $display("start op=0 src=60 dst=c0 count=4 (reset in second write)");
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("abort_strobe", {63'd0, data_mem_write}, 64'd0);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (10) @(posedge clk);
        chk("abort_no_done", 64'(done_seen), 64'(d0));
        chk("abort_writes_left", 64'(exp_wr.size()), 64'd0);
        mem_compare("abort_mem");
        exp_wr.delete();

        for (int t = 0; t < 12; t++) begin
            run(1'($urandom), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 20)), $urandom, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_copy_engine.md
# mem_copy_engine

Data-port initiator that moves or fills blocks of words in the 256 × 32-bit unified CPU memory without CPU involvement. It drives the memory's data port (write strobe, 8-bit word address, 32-bit write data) and consumes its combinational read data. It sits beside the CPU and owns the data port only while `busy` is high; external muxing of the port is outside this block.

## Interface
- `ADDR_W`, 8: word-address width; memory depth is 2^ADDR_W.
- `DATA_W`, 32: word width.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: request a transfer; sampled only in IDLE.
- `op` in 1: 0 = copy, 1 = fill; sampled with `start`.
- `src_addr` in ADDR_W: first source word (copy only).
- `dst_addr` in ADDR_W: first destination word.
- `count` in ADDR_W+1: words to transfer, 0..256.
- `fill_value` in DATA_W: word written in fill mode.
- `busy` out 1: transfer in progress.
- `done` out 1: one-cycle completion pulse.
- `data_mem_write` out 1: memory write strobe.
- `data_address` out ADDR_W: memory word address.
- `data_write_data` out DATA_W: memory write data.
- `data_read_data` in DATA_W: memory read data, combinational from `data_address`.

## Operation
- States: IDLE, READ, WRITE, FILL, DONE.
- IDLE: `start`=1 latches `op`, `src_addr`, `dst_addr`, `count`, `fill_value`; clears index. count=0 → DONE; op=0 → READ; op=1 → FILL.
- READ: `data_address`=src+idx, strobe 0; at the clock edge `hold`←`data_read_data`; → WRITE.
- WRITE: `data_address`=dst+idx, `data_write_data`=`hold`, strobe 1; at the clock edge idx++; idx+1==count → DONE, else → READ.
- FILL: `data_address`=dst+idx, `data_write_data`=fill_value, strobe 1; at the clock edge idx++; idx+1==count → DONE, else stay.
- DONE: `done`=1 for one cycle, strobe 0; → IDLE.
- `busy`=1 in READ, WRITE, FILL; 0 in IDLE and DONE.
- Address arithmetic is modulo 2^ADDR_W; src and dst wrap 0xFF→0x00 independently.
- The index counter is ADDR_W+1 bits so that count=256 terminates correctly.
- Words transfer in ascending index order. Overlapping regions with dst > src replicate data; this is defined behaviour, not an error.
- `start` outside IDLE, including in DONE, is ignored. Inputs other than `start` are don't-care outside the IDLE sample.
- All outputs decode from registered state only; no input-to-output combinational path.
- In IDLE and DONE, `data_address` and `data_write_data` drive 0.

## Timing
- Reset (async assert, sync release): state IDLE, idx 0, hold 0; `busy`, `done`, `data_mem_write` 0; `data_address`, `data_write_data` 0.
- Reset mid-transfer aborts immediately: the strobe drops without waiting for a clock, no further writes occur, and no `done` pulse is produced.
- Copy: 2 cycles per word. `done` asserts 2·count+1 cycles after the `start` edge.
- Fill: 1 cycle per word. `done` asserts count+1 cycles after the `start` edge.
- count=0: `done` asserts in the cycle after the `start` edge, with no strobe.
- `start` held high continuously relaunches in the cycle after DONE.

## Structure
- Shared package `mem_copy_pkg` holds:
  - the state enum;
  - op codes `OP_COPY`=0 and `OP_FILL`=1;
  - constants `MEM_ADDR_W`=8, `MEM_DATA_W`=32, `MEM_WORDS`=256 (also used by the memory model).
- No sub-module: one FSM plus index counter, hold register and address adders.
- Estimated size: about 150–200 lines.

## Test plan
- **Copy:** memory preloaded with words[0x10..0x13]=A,B,C,D; copy src 0x10, dst 0x80, count 4 → words[0x80..0x83]=A,B,C,D; exactly 4 strobes; `done` 9 cycles after `start`; source unchanged.
- **Fill:** fill dst 0x20, count 3, value 0xDEADBEEF → words 0x20–0x22 = 0xDEADBEEF; word 0x23 untouched; `done` 4 cycles after `start`.
- **Wrap and full range:**
  - Copy src 0xFE, dst 0x40, count 4 → reads 0xFE, 0xFF, 0x00, 0x01 in order.
  - Fill count 256 → all words written once; 256 strobes.
- **count=0:** zero strobes; `done` 1 cycle after `start`; `busy` never high.
- **Overlap:** copy src 0x10, dst 0x11, count 3 with words[0x10..0x12]=1,2,3 → words[0x11..0x13]=1,1,1.
- **Reset and ignored start:**
  - `rst` low during the second WRITE of a count-4 copy → strobe drops immediately; only one word written; no `done`.
  - `start` pulsed while `busy` → ignored; the first transfer completes unchanged.
